priority_encoder_4to2: RTL and testbench



---
 rtl/priority_encoder_pkg.sv | 12 +
 rtl/priority_encoder_core.sv | 23 ++
 rtl/priority_encoder_4to2.sv | 60 ++++++
 tb/tb_priority_encoder_4to2.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/priority_encoder_pkg.sv
// Shared constants for the 4-to-2 priority encoder: the 2-bit index codes
// and the default choice of registered versus combinational outputs.
package priority_encoder_pkg;

    localparam logic [1:0] IDX0 = 2'b00;
    localparam logic [1:0] IDX1 = 2'b01;
    localparam logic [1:0] IDX2 = 2'b10;
    localparam logic [1:0] IDX3 = 2'b11;

    localparam bit OUT_REG_DEFAULT = 1'b1;

endpackage : priority_encoder_pkg

// File: rtl/priority_encoder_core.sv
// Purely combinational priority encoder; i3 has the highest priority.
module priority_encoder_core
    import priority_encoder_pkg::*;
(
    input  logic       i0,
    input  logic       i1,
    input  logic       i2,
    input  logic       i3,
    output logic [1:0] code,
    output logic       valid
);

    // The ternary chain only looks at a lower request when every higher one
    // is 0, so X on a masked input never reaches the outputs.
    always_comb begin
        code  = IDX0;
        valid = i3 | i2 | i1 | i0;
        code  = i3 ? IDX3 :
                i2 ? IDX2 :
                i1 ? IDX1 : IDX0;
    end

endmodule : priority_encoder_core

// File: rtl/priority_encoder_4to2.sv
// 4-to-2 priority encoder top: wraps the combinational core with an
// optional output register selected by OUT_REG.
module priority_encoder_4to2
    import priority_encoder_pkg::*;
#(
    parameter bit OUT_REG = OUT_REG_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i0,
    input  logic i1,
    input  logic i2,
    input  logic i3,
    output logic o0,
    output logic o1,
    output logic valid
);

    logic [1:0] code_d;
    logic       valid_d;

    priority_encoder_core u_core (
        .i0    (i0),
        .i1    (i1),
        .i2    (i2),
        .i3    (i3),
        .code  (code_d),
        .valid (valid_d)
    );

    generate
        if (OUT_REG) begin : g_reg
            logic [1:0] code_q;
            logic       valid_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    code_q  <= IDX0;
                    valid_q <= 1'b0;
                end else begin
                    code_q  <= code_d;
                    valid_q <= valid_d;
                end
            end

            assign o1    = code_q[1];
            assign o0    = code_q[0];
            assign valid = valid_q;
        end else begin : g_comb
            // Clock and reset are intentionally ignored in this mode.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;

            assign o1    = code_d[1];
            assign o0    = code_d[0];
            assign valid = valid_d;
        end
    endgenerate

endmodule : priority_encoder_4to2

// File: tb/tb_priority_encoder_4to2.sv
// Self-checking bench for priority_encoder_4to2: registered and
// combinational instances driven from the same request inputs.
module tb_priority_encoder_4to2;

    typedef struct {
        logic [3:0] req;
        logic [2:0] expect_out;
    } vec_t;

    logic clk;
    logic rst_n;
    logic i0, i1, i2, i3;
    logic r_o0, r_o1, r_valid;
    logic c_o0, c_o1, c_valid;

    int assertions_evaluated;
    int failures;
    logic [2:0] prev_expect;
    vec_t table_vecs [8];

    priority_encoder_4to2 #(.OUT_REG(1'b1)) u_dut_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .i0    (i0),
        .i1    (i1),
        .i2    (i2),
        .i3    (i3),
        .o0    (r_o0),
        .o1    (r_o1),
        .valid (r_valid)
    );

    priority_encoder_4to2 #(.OUT_REG(1'b0)) u_dut_comb (
        .clk   (clk),
        .rst_n (rst_n),
        .i0    (i0),
        .i1    (i1),
        .i2    (i2),
        .i3    (i3),
        .o0    (c_o0),
        .o1    (c_o1),
        .valid (c_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: index of the highest request that is 1, plus an any-request flag.
    function automatic logic [2:0] ref_model(input logic [3:0] req);
        for (int k = 3; k >= 0; k--) begin
            if (req[k] === 1'b1) return {2'(k), 1'b1};
        end
        return 3'b000;
    endfunction

    task automatic applyStimulus(input logic [3:0] req);
        {i3, i2, i1, i0} = req;
    endtask

    task automatic checkOutput(input string name, input logic [2:0] got, input logic [2:0] exp);
        assertions_evaluated++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got {o1,o0,valid}=%b, expected %b", name, got, exp);
        end
    endtask

    // Drive on the falling edge, check the combinational copy at once and the
    // registered copy both before (old value) and after the next rising edge.
    task automatic runVector(input string name, input logic [3:0] req, input logic [2:0] exp);
        @(negedge clk);
        applyStimulus(req);
        #1;
        checkOutput({name, "_comb"}, {c_o1, c_o0, c_valid}, exp);
        checkOutput({name, "_reg_hold"}, {r_o1, r_o0, r_valid}, prev_expect);
        @(posedge clk);
        #1;
        checkOutput({name, "_reg"}, {r_o1, r_o0, r_valid}, exp);
        prev_expect = exp;
    endtask

    initial begin
        assertions_evaluated = 0;
        failures             = 0;

        table_vecs[0] = '{req: 4'b0001, expect_out: 3'b001};
        table_vecs[1] = '{req: 4'b0010, expect_out: 3'b011};
        table_vecs[2] = '{req: 4'b0100, expect_out: 3'b101};
        table_vecs[3] = '{req: 4'b1000, expect_out: 3'b111};
        table_vecs[4] = '{req: 4'b001x, expect_out: 3'b011};
        table_vecs[5] = '{req: 4'b01xx, expect_out: 3'b101};
        table_vecs[6] = '{req: 4'b1xxx, expect_out: 3'b111};
        table_vecs[7] = '{req: 4'b0000, expect_out: 3'b000};

        // Reset behaviour, no clock edge involved in the first checks.
        rst_n = 1'b0;
        applyStimulus(4'b0000);
        #2;
        checkOutput("reset_idle_reg", {r_o1, r_o0, r_valid}, 3'b000);
        checkOutput("reset_idle_comb", {c_o1, c_o0, c_valid}, 3'b000);
        applyStimulus(4'b1111);
        #1;
        checkOutput("reset_all_req_reg", {r_o1, r_o0, r_valid}, 3'b000);
        checkOutput("reset_ignored_comb", {c_o1, c_o0, c_valid}, 3'b111);
        @(posedge clk);
        #1;
        checkOutput("reset_held_over_edge", {r_o1, r_o0, r_valid}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("reset_release_no_edge", {r_o1, r_o0, r_valid}, 3'b000);
        @(posedge clk);
        #1;
        checkOutput("first_capture", {r_o1, r_o0, r_valid}, 3'b111);

        // Reset asserted mid-cycle with requests active clears immediately.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_reset_reg", {r_o1, r_o0, r_valid}, 3'b000);
        checkOutput("mid_reset_comb", {c_o1, c_o0, c_valid}, 3'b111);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mid_reset_recapture", {r_o1, r_o0, r_valid}, 3'b111);
        prev_expect = 3'b111;

        // One-hot walk, don't-care lower bits, idle then i0-only.
        foreach (table_vecs[n])
            runVector($sformatf("table%0d", n), table_vecs[n].req, table_vecs[n].expect_out);
        runVector("idle_then_i0", 4'b0001, 3'b001);

        for (int p = 0; p < 16; p++)
            runVector($sformatf("exh_%b", 4'(p)), 4'(p), ref_model(4'(p)));

        for (int r = 0; r < 60; r++) begin
            logic [3:0] rnd;
            rnd = 4'($urandom_range(0, 15));
            runVector($sformatf("rand%0d_%b", r, rnd), rnd, ref_model(rnd));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions_evaluated, failures);
        $finish;
    end

endmodule : tb_priority_encoder_4to2
